// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// Holds the FSM state enum, header packing helper and field widths.
package router_pkg;

    localparam int MAX_LEN = 63;
    localparam int ADDR_W  = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PLD,
        PAR,
        GAP
    } tx_state_t;

    function automatic logic [7:0] hdr_pack(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] dest
    );
        return {len, dest};
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Bundle of the transmitter's buffer, request and router-side signals.
// slave: the transmitter's view; master: the driver/router side view.
interface router_pkt_tx_if #(
    parameter int DEPTH = 64
);
    import router_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [7:0]        wr_data;
    logic              buf_full;
    logic [CW-1:0]     buf_count;
    logic              wr_ovf;
    logic              start;
    logic [ADDR_W-1:0] dest;
    logic [LEN_W-1:0]  len;
    logic              corrupt;
    logic              start_ready;
    logic              busy;
    logic [7:0]        data_out;
    logic              pkt_valid;
    logic              tx_active;
    logic              pkt_done;
    logic [15:0]       pkt_cnt;

    modport slave (
        input  wr_en, wr_data, start, dest, len, corrupt, busy,
        output buf_full, buf_count, wr_ovf, start_ready,
        output data_out, pkt_valid, tx_active, pkt_done, pkt_cnt
    );

    modport master (
        output wr_en, wr_data, start, dest, len, corrupt, busy,
        input  buf_full, buf_count, wr_ovf, start_ready,
        input  data_out, pkt_valid, tx_active, pkt_done, pkt_cnt
    );

endinterface

// File: rtl/router_tx_buf.sv
// First-word-fall-through payload FIFO with drop-on-full overflow pulse.
// Ports: i_push/i_data write, i_pop read, o_head, o_count, o_full, o_ovf.
module router_tx_buf #(
    parameter int DEPTH = 64
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic w_full;
    logic w_push;
    logic w_pop;

    // Full comes from the count register, so the write decision
    // uses the occupancy as it stood before this edge.
    assign w_full = (r_count == CW'(DEPTH));
    assign w_push = i_push && !w_full;
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= i_push && w_full;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: header, buffered payload, then parity byte.
// Ports: clock, reset, bus (slave view of router_pkt_tx_if).
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IFG   = 2
) (
    input  logic            clock,
    input  logic            reset,
    router_pkt_tx_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;

    tx_state_t        r_state;
    logic [7:0]       r_data;
    logic [7:0]       r_par;
    logic             r_valid;
    logic             r_active;
    logic             r_done;
    logic             r_corrupt;
    logic [LEN_W-1:0] r_rem;
    logic [15:0]      r_cnt;
    logic [GW-1:0]    r_gap;

    logic [7:0]       w_head;
    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_ovf;
    logic             w_pop;
    logic             w_ready;

    // Pop exactly when a header/payload byte is consumed and more
    // payload is still owed.
    assign w_pop = !bus.busy && (r_rem != '0) &&
                   ((r_state == HDR) || (r_state == PLD));

    assign w_ready = (r_state == IDLE) && (bus.len != '0) &&
                     (w_count >= CW'(bus.len));

    router_tx_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .i_clock (clock),
        .i_reset (reset),
        .i_push  (bus.wr_en),
        .i_data  (bus.wr_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_par     <= '0;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
            r_corrupt <= 1'b0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start && w_ready) begin
                        r_state   <= HDR;
                        r_data    <= hdr_pack(bus.len, bus.dest);
                        r_par     <= hdr_pack(bus.len, bus.dest);
                        r_valid   <= 1'b1;
                        r_active  <= 1'b1;
                        r_rem     <= bus.len;
                        r_corrupt <= bus.corrupt;
                    end
                end
                HDR, PLD: begin
                    if (!bus.busy) begin
                        if (r_rem != '0) begin
                            r_data  <= w_head;
                            r_par   <= r_par ^ w_head;
                            r_rem   <= r_rem - 1'b1;
                            r_state <= PLD;
                        end else begin
                            r_data  <= r_par ^ {8{r_corrupt}};
                            r_valid <= 1'b0;
                            r_state <= PAR;
                        end
                    end
                end
                PAR: begin
                    if (!bus.busy) begin
                        r_data   <= '0;
                        r_done   <= 1'b1;
                        r_active <= 1'b0;
                        r_cnt    <= r_cnt + 16'd1;
                        r_gap    <= '0;
                        r_state  <= (IFG == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (r_gap == GW'((IFG > 0) ? IFG - 1 : 0)) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.buf_full    = w_full;
    assign bus.buf_count   = w_count;
    assign bus.wr_ovf      = w_ovf;
    assign bus.start_ready = w_ready;
    assign bus.data_out    = r_data;
    assign bus.pkt_valid   = r_valid;
    assign bus.tx_active   = r_active;
    assign bus.pkt_done    = r_done;
    assign bus.pkt_cnt     = r_cnt;

endmodule
